pipelined_adder: RTL and testbench

Parametrised, pipelined successor to the combinational 16-bit ripple adder. Adds or subtracts two WIDTH-bit operands with carry-in. The carry chain is split into STAGES equal segments, one register stage per segment. Accepts one operation per cycle through a valid/ready handshake with full backpressure. Sits in the arithmetic datapath, where multiplier partial-sum accumulation and ALU paths need a width-scalable adder that meets timing.

---
 rtl/adder_pkg.sv | 12 +
 rtl/adder_segment.sv | 29 ++
 rtl/full_adder.sv | 13 +
 rtl/pipelined_adder.sv | 123 ++++++++++++
 tb/tb_pipelined_adder.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: operation encodings and the
// carry-chain segment width helper.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit ripple slice built from full-adder cells; one slice
// per pipeline stage of the pipelined adder.
module adder_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           c_i,
  output logic [SEG-1:0] sum_o,
  output logic           c_o
);

  logic [SEG:0] carry;

  assign carry[0] = c_i;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (carry[i]),
      .s_o (sum_o[i]),
      .c_o (carry[i+1])
    );
  end

  assign c_o = carry[SEG];

endmodule

// File: rtl/full_adder.sv
// One-bit full-adder cell, the building block of every ripple slice.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract with the carry chain cut into STAGES registered
// segments; valid/ready handshake with a global stall on output backpressure.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             c_out,
  output logic             overflow
);

  localparam int SEG = seg_width(WIDTH, STAGES);
  localparam int L   = STAGES - 1;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_cfg_err
    $error("pipelined_adder: WIDTH must be a nonzero multiple of STAGES");
  end

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic              stall;

  assign stall    = vld_q[L] & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_src, b_src, s_src, s_new;
    logic             c_src, v_src;
    logic [SEG-1:0]   seg_sum;
    logic             seg_c;

    // Stage 0 boundary: operands enter here with B already inverted for subtract
    if (k == 0) begin : g_first
      assign a_src = a;
      assign b_src = (sub == OP_SUB) ? ~b : b;
      assign c_src = (sub == OP_SUB) ? 1'b1 : c_in;
      assign s_src = '0;
      assign v_src = in_valid;
    end else begin : g_next
      assign a_src = a_q[k-1];
      assign b_src = b_q[k-1];
      assign c_src = c_q[k-1];
      assign s_src = s_q[k-1];
      assign v_src = vld_q[k-1];
    end

    adder_segment #(.SEG(SEG)) u_seg (
      .a_i   (a_src[k*SEG +: SEG]),
      .b_i   (b_src[k*SEG +: SEG]),
      .c_i   (c_src),
      .sum_o (seg_sum),
      .c_o   (seg_c)
    );

    always_comb begin
      s_new                = s_src;
      s_new[k*SEG +: SEG]  = seg_sum;
    end

    assign a_d[k]   = a_src;
    assign b_d[k]   = b_src;
    assign s_d[k]   = s_new;
    assign c_d[k]   = seg_c;
    assign vld_d[k] = v_src;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (!stall) begin
      vld_q <= vld_d;
    end
  end

  // Output stage boundary: only the last stage is reset and it loads on valid
  // data only, so out holds the last result across bubbles.
  always_ff @(posedge clk) begin
    if (!stall) begin
      for (int k = 0; k < L; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
    end
    if (rst) begin
      a_q[L] <= '0;
      b_q[L] <= '0;
      s_q[L] <= '0;
      c_q[L] <= 1'b0;
    end else if (!stall && vld_d[L]) begin
      a_q[L] <= a_d[L];
      b_q[L] <= b_d[L];
      s_q[L] <= s_d[L];
      c_q[L] <= c_d[L];
    end
  end

  assign out_valid = vld_q[L];
  assign out       = s_q[L];
  assign c_out     = c_q[L];
  assign overflow  = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) &
                     (s_q[L][WIDTH-1] != a_q[L][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder at WIDTH=16, STAGES=4.
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         c_out;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  task automatic drive(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tc, input logic ts);
    in_valid = v; a = ta; b = tb_; c_in = tc; sub = ts;
  endtask

  // Issues one op at the current cycle and waits (bounded) for its result.
  task automatic issue_and_wait(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                input logic tc, input logic ts, output int lat,
                                output logic [W-1:0] ro, output logic rc, output logic rov);
    lat = -1; ro = 'x; rc = 1'bx; rov = 1'bx;
    drive(1'b1, ta, tb_, tc, ts);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = i; ro = out; rc = c_out; rov = overflow;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (out !== 16'h0000) begin n_fail++; $display("FAIL reset_out got=%h exp=0000", out); end
    n_checks++; if (c_out !== 1'b0) begin n_fail++; $display("FAIL reset_c_out got=%b exp=0", c_out); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    int lat; logic [W-1:0] r; logic rc, rov;
    issue_and_wait(16'd1, 16'd10, 1'b0, 1'b0, lat, r, rc, rov);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL single_latency got=%0d exp=4", lat); end
    n_checks++; if (r !== 16'd11) begin n_fail++; $display("FAIL single_1p10 got=%0d exp=11", r); end
    n_checks++; if (rc !== 1'b0) begin n_fail++; $display("FAIL single_1p10_cout got=%b exp=0", rc); end
    issue_and_wait(16'd94, 16'd333, 1'b0, 1'b0, lat, r, rc, rov);
    n_checks++; if (r !== 16'd427) begin n_fail++; $display("FAIL single_94p333 got=%0d exp=427", r); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL single_94p333_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_carry_ripple;
    int lat; logic [W-1:0] r; logic rc, rov;
    issue_and_wait(16'hFFFF, 16'h0000, 1'b1, 1'b0, lat, r, rc, rov);
    n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL ripple_ffff got=%h exp=0000", r); end
    n_checks++; if (rc !== 1'b1) begin n_fail++; $display("FAIL ripple_ffff_cout got=%b exp=1", rc); end
    n_checks++; if (rov !== 1'b0) begin n_fail++; $display("FAIL ripple_ffff_ovf got=%b exp=0", rov); end
    issue_and_wait(16'h0FFF, 16'h0001, 1'b0, 1'b0, lat, r, rc, rov);
    n_checks++; if (r !== 16'h1000) begin n_fail++; $display("FAIL ripple_0fff got=%h exp=1000", r); end
    n_checks++; if (rc !== 1'b0) begin n_fail++; $display("FAIL ripple_0fff_cout got=%b exp=0", rc); end
  endtask

  task automatic test_sub_flags;
    int lat; logic [W-1:0] r; logic rc, rov;
    issue_and_wait(16'd5, 16'd7, 1'b0, 1'b1, lat, r, rc, rov);
    n_checks++; if (r !== 16'hFFFE) begin n_fail++; $display("FAIL sub_5m7 got=%h exp=fffe", r); end
    n_checks++; if (rc !== 1'b0) begin n_fail++; $display("FAIL sub_5m7_cout got=%b exp=0", rc); end
    n_checks++; if (rov !== 1'b0) begin n_fail++; $display("FAIL sub_5m7_ovf got=%b exp=0", rov); end
    issue_and_wait(16'd7, 16'd5, 1'b1, 1'b1, lat, r, rc, rov);
    n_checks++; if (r !== 16'h0002) begin n_fail++; $display("FAIL sub_7m5 got=%h exp=0002", r); end
    n_checks++; if (rc !== 1'b1) begin n_fail++; $display("FAIL sub_7m5_cout got=%b exp=1", rc); end
    issue_and_wait(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, r, rc, rov);
    n_checks++; if (r !== 16'h8000) begin n_fail++; $display("FAIL ovf_7fff got=%h exp=8000", r); end
    n_checks++; if (rov !== 1'b1) begin n_fail++; $display("FAIL ovf_7fff_ovf got=%b exp=1", rov); end
    n_checks++; if (rc !== 1'b0) begin n_fail++; $display("FAIL ovf_7fff_cout got=%b exp=0", rc); end
    issue_and_wait(16'h8000, 16'h8000, 1'b0, 1'b0, lat, r, rc, rov);
    n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL ovf_8000 got=%h exp=0000", r); end
    n_checks++; if (rc !== 1'b1) begin n_fail++; $display("FAIL ovf_8000_cout got=%b exp=1", rc); end
    n_checks++; if (rov !== 1'b1) begin n_fail++; $display("FAIL ovf_8000_ovf got=%b exp=1", rov); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] exp_q [3] = '{16'd46, 16'd1606, 16'd427};
    drive(1'b1, 16'd15, 16'd31, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 16'd128, 16'd1478, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 16'd94, 16'd333, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early got=%b exp=0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_result%0d got valid=%b out=%0d exp valid=1 out=%0d", i, out_valid, out, exp_q[i]);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_tail got=%b exp=0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic [W-1:0] exp_q [4] = '{16'd3, 16'd30, 16'd300, 16'd3000};
    logic [W-1:0] op_a  [4] = '{16'd1, 16'd10, 16'd100, 16'd1000};
    logic [W-1:0] op_b  [4] = '{16'd2, 16'd20, 16'd200, 16'd2000};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, op_a[i], op_b[i], 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready%0d got=%b exp=0", i, in_ready); end
      n_checks++;
      if (out_valid !== 1'b1 || out !== 16'd3) begin
        n_fail++; $display("FAIL bp_hold%0d got valid=%b out=%0d exp valid=1 out=3", i, out_valid, out);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_drain%0d got valid=%b out=%0d exp valid=1 out=%0d", i, out_valid, out, exp_q[i]);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_tail got=%b exp=0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat; logic [W-1:0] r; logic rc, rov;
    logic stale;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 16'(i), 16'(i), 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (out !== 16'h0000) begin n_fail++; $display("FAIL rmid_out got=%h exp=0000", out); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    n_checks++; if (stale !== 1'b0) begin n_fail++; $display("FAIL rmid_stale got=%b exp=0", stale); end
    @(posedge clk); #1;
    issue_and_wait(16'd3, 16'd4, 1'b0, 1'b0, lat, r, rc, rov);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rmid_new_latency got=%0d exp=4", lat); end
    n_checks++; if (r !== 16'd7) begin n_fail++; $display("FAIL rmid_new_out got=%0d exp=7", r); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry_ripple();
    test_sub_flags();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
